// File: rtl/usb_rx_decode.sv
// -----------------------------------------------------------------------------
// usb_rx_decode
//   Receive-side line decoder for USB full-speed. Synchronises the raw D+/D-
//   lines, recovers bit timing from D+ edges, NRZI-decodes the line, drops
//   stuffed zeros and detects end-of-packet and stuffing/EOP errors.
//
// Parameters
//   CLKS_PER_BIT  system clocks per USB bit period (even, >= 4)
//   STUFF_LIMIT   consecutive decoded 1s after which a stuffed 0 is expected
//
// Ports
//   clk           system clock
//   rst           asynchronous active-high reset
//   d_plus        raw D+ line, asynchronous to clk
//   d_minus       raw D- line, asynchronous to clk
//   d_orig        decoded data bit, valid while shift_enable is high
//   shift_enable  one-cycle strobe per delivered data bit
//   receiving     high from packet start until EOP or error recovery
//   eop           one-cycle pulse on a valid end of packet
//   rx_error      one-cycle pulse on a stuff violation or malformed EOP
// -----------------------------------------------------------------------------
module usb_rx_decode #(
  parameter int CLKS_PER_BIT = 8,
  parameter int STUFF_LIMIT  = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic d_plus,
  input  logic d_minus,
  output logic d_orig,
  output logic shift_enable,
  output logic receiving,
  output logic eop,
  output logic rx_error
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int OW = $clog2(STUFF_LIMIT + 1);

  localparam logic [CW-1:0] SAMPLE_AT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [OW-1:0] ONES_MAX  = OW'(STUFF_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_EOP_SE0,
    S_ERROR
  } state_t;

  // Synchroniser and edge-history flops
  logic r_dp_meta, r_dp_s, r_dp_d;
  logic r_dm_meta, r_dm_s;

  // Timing recovery and decode state
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_prev;      // line level (D+) of the previous decoded bit
  logic [OW-1:0]   r_ones;      // run length of consecutive decoded 1s
  logic [1:0]      r_se0_cnt;   // SE0 bit times seen while looking for EOP
  logic            r_err_se0;   // SE0 seen while recovering from an error

  // Registered outputs
  logic r_d_orig, r_shift_en, r_eop, r_rx_err;

  // Combinational decode
  state_t          w_state_next;
  logic            w_edge, w_sample, w_j, w_k, w_se0, w_bit;
  logic [CW-1:0]   w_cnt_inc, w_cnt_next;
  logic            w_prev_next;
  logic [OW-1:0]   w_ones_next;
  logic [1:0]      w_se0_next;
  logic            w_err_se0_next;
  logic            w_deliver, w_eop_set, w_err_set, w_receiving;

  // ---------------------------------------------------------------------------
  // Input synchronisers. They reset to the J idle level so that leaving reset
  // never looks like a line edge or a K.
  // ---------------------------------------------------------------------------
  // NOTE: flops are written with <= so every register samples the values from
  // before the clock edge; blocking writes here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dp_meta <= 1'b1;
      r_dp_s    <= 1'b1;
      r_dp_d    <= 1'b1;
      r_dm_meta <= 1'b0;
      r_dm_s    <= 1'b0;
    end else begin
      r_dp_meta <= d_plus;
      r_dp_s    <= r_dp_meta;
      r_dp_d    <= r_dp_s;
      r_dm_meta <= d_minus;
      r_dm_s    <= r_dm_meta;
    end
  end

  assign w_j    =  r_dp_s & ~r_dm_s;
  assign w_k    = ~r_dp_s &  r_dm_s;
  assign w_se0  = ~r_dp_s & ~r_dm_s;
  assign w_edge = r_dp_s ^ r_dp_d;

  // NRZI: no change in level decodes as 1, a transition as 0.
  assign w_bit = (r_dp_s == r_prev);

  // An edge on the sample cycle resyncs the counter and defers the sample.
  assign w_sample  = (r_cnt == SAMPLE_AT) && !w_edge;
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? '0 : r_cnt + CW'(1);
  // In IDLE the first K marks the start of the first SYNC bit; elsewhere any
  // D+ edge realigns the bit clock.
  assign w_cnt_next = ((r_state == S_IDLE) ? w_k : w_edge) ? CW'(1) : w_cnt_inc;

  // ---------------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_k) w_state_next = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (w_sample) begin
          if (w_se0)                             w_state_next = S_EOP_SE0;
          else if (r_ones == ONES_MAX && w_bit)  w_state_next = S_ERROR;
        end
      end
      S_EOP_SE0: begin
        if (w_sample) begin
          if (w_se0) begin
            if (r_se0_cnt == 2'd2) w_state_next = S_ERROR;
          end else if (w_k) begin
            w_state_next = S_ERROR;
          end else begin
            // J or SE1 after one or two SE0 bit times
            w_state_next = S_IDLE;
          end
        end
      end
      S_ERROR: begin
        if (w_sample && r_err_se0 && !w_se0 && !w_k) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: outputs and datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    w_deliver      = 1'b0;
    w_eop_set      = 1'b0;
    w_err_set      = 1'b0;
    w_prev_next    = r_prev;
    w_ones_next    = r_ones;
    w_se0_next     = r_se0_cnt;
    w_err_se0_next = r_err_se0;
    w_receiving    = (r_state != S_IDLE);

    unique case (r_state)
      S_IDLE: begin
        if (w_k) begin
          w_prev_next    = 1'b1;
          w_ones_next    = '0;
          w_se0_next     = '0;
          w_err_se0_next = 1'b0;
        end
      end
      S_ACTIVE: begin
        if (w_sample) begin
          if (w_se0) begin
            w_se0_next = 2'd1;
          end else begin
            w_prev_next = r_dp_s;
            if (r_ones == ONES_MAX) begin
              // A 0 here is the stuffed bit and is swallowed; a 1 means the
              // transmitter failed to stuff.
              if (w_bit) begin
                w_err_set      = 1'b1;
                w_err_se0_next = 1'b0;
              end else begin
                w_ones_next = '0;
              end
            end else begin
              w_deliver   = 1'b1;
              w_ones_next = w_bit ? r_ones + OW'(1) : '0;
            end
          end
        end
      end
      S_EOP_SE0: begin
        if (w_sample) begin
          if (w_se0) begin
            w_se0_next = r_se0_cnt + 2'd1;
            if (r_se0_cnt == 2'd2) begin
              w_err_set      = 1'b1;
              w_err_se0_next = 1'b0;
            end
          end else if (w_k) begin
            w_err_set      = 1'b1;
            w_err_se0_next = 1'b0;
          end else begin
            w_eop_set = 1'b1;
          end
        end
      end
      S_ERROR: begin
        // Only an SE0 immediately followed by J/SE1 ends error recovery.
        if (w_sample) w_err_se0_next = w_se0;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_prev     <= 1'b1;
      r_ones     <= '0;
      r_se0_cnt  <= '0;
      r_err_se0  <= 1'b0;
      r_d_orig   <= 1'b1;
      r_shift_en <= 1'b0;
      r_eop      <= 1'b0;
      r_rx_err   <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_next;
      r_prev     <= w_prev_next;
      r_ones     <= w_ones_next;
      r_se0_cnt  <= w_se0_next;
      r_err_se0  <= w_err_se0_next;
      r_shift_en <= w_deliver;
      r_eop      <= w_eop_set;
      r_rx_err   <= w_err_set;
      // d_orig holds its last delivered value between strobes
      if (w_deliver) r_d_orig <= w_bit;
    end
  end

  assign d_orig       = r_d_orig;
  assign shift_enable = r_shift_en;
  assign receiving    = w_receiving;
  assign eop          = r_eop;
  assign rx_error     = r_rx_err;

endmodule

// File: tb/tb_usb_rx_decode.sv
// -----------------------------------------------------------------------------
// tb_usb_rx_decode
//   Self-checking bench for usb_rx_decode. Packets are described as plain
//   data-bit lists; the bench NRZI-encodes them (with bit stuffing) onto the
//   D+/D- lines and expects the decoder to return the same bit list.
// -----------------------------------------------------------------------------
module tb_usb_rx_decode;

  localparam int CPB   = 8;
  localparam int LIMIT = 6;

  logic clk = 1'b0;
  logic rst;
  logic d_plus, d_minus;
  logic d_orig, shift_enable, receiving, eop, rx_error;

  usb_rx_decode #(.CLKS_PER_BIT(CPB), .STUFF_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .d_plus       (d_plus),
    .d_minus      (d_minus),
    .d_orig       (d_orig),
    .shift_enable (shift_enable),
    .receiving    (receiving),
    .eop          (eop),
    .rx_error     (rx_error)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Output monitor (samples on the falling edge, away from output updates)
  // ---------------------------------------------------------------------------
  bit rx_q[$];
  int eop_n, err_n, excl_n, bad_rcv, eop_cyc;
  bit rcv_seen, prev_rcv;

  task automatic clear_mon();
    rx_q.delete();
    eop_n = 0; err_n = 0; excl_n = 0; bad_rcv = 0; eop_cyc = 0;
    rcv_seen = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_rcv = 1'b0;
    end else begin
      if (shift_enable) rx_q.push_back(d_orig);
      if (eop) begin
        eop_n++;
        eop_cyc = cyc;
        // receiving must fall in the same cycle eop rises
        if (receiving || !prev_rcv) bad_rcv++;
      end
      if (rx_error) begin
        err_n++;
        if (!receiving) bad_rcv++;
      end
      if (receiving) rcv_seen = 1'b1;
      if (int'(shift_enable) + int'(eop) + int'(rx_error) > 1) excl_n++;
      prev_rcv = receiving;
    end
  end

  // ---------------------------------------------------------------------------
  // Line driver / encoder model
  // ---------------------------------------------------------------------------
  bit tx_bits[$];    // data bits of the packet, SYNC included, before stuffing
  bit lvl;           // current line level: 1 = J, 0 = K
  bit drift;         // alternate 7/9 clock bit periods
  int bit_idx;
  int j_cyc;

  function automatic int bit_period();
    if (!drift) return CPB;
    return bit_idx[0] ? CPB + 1 : CPB - 1;
  endfunction

  task automatic emit_line(input logic dp, input logic dm, input int n);
    d_plus  = dp;
    d_minus = dm;
    repeat (n) @(negedge clk);
  endtask

  task automatic emit_bit(input bit b);
    int p;
    p = bit_period();
    if (!b) lvl = !lvl;
    bit_idx++;
    emit_line(lvl, !lvl, p);
  endtask

  // Sends at most max_line line bits of tx_bits, inserting stuffed zeros.
  task automatic send_stream(input bit stuff, input int max_line);
    int ones = 0;
    int sent = 0;
    foreach (tx_bits[i]) begin
      if (sent >= max_line) return;
      emit_bit(tx_bits[i]);
      sent++;
      ones = tx_bits[i] ? ones + 1 : 0;
      if (stuff && ones == LIMIT) begin
        if (sent >= max_line) return;
        emit_bit(1'b0);
        sent++;
        ones = 0;
      end
    end
  endtask

  task automatic send_eop(input int n_se0);
    int p;
    repeat (n_se0) begin
      p = bit_period();
      bit_idx++;
      emit_line(1'b0, 1'b0, p);
    end
    p = bit_period();
    bit_idx++;
    j_cyc = cyc;
    lvl = 1'b1;
    emit_line(1'b1, 1'b0, p);
    emit_line(1'b1, 1'b0, 40);
  endtask

  task automatic load_sync();
    tx_bits.delete();
    repeat (7) tx_bits.push_back(1'b0);
    tx_bits.push_back(1'b1);
  endtask

  // Sends tx_bits as one packet and compares everything the decoder produced.
  task automatic run_packet(input string name, input bit stuff, input bit drift_en,
                            input int n_se0, input int exp_strobes,
                            input bit exp_eop, input bit exp_err);
    int bad_bits = 0;
    clear_mon();
    drift   = drift_en;
    bit_idx = 0;
    lvl     = 1'b1;
    emit_line(1'b1, 1'b0, 12);
    send_stream(stuff, 1 << 30);
    send_eop(n_se0);
    check({name, ":strobes"}, 32'(rx_q.size()), 32'(exp_strobes));
    for (int i = 0; i < rx_q.size() && i < tx_bits.size(); i++)
      if (rx_q[i] !== tx_bits[i]) bad_bits++;
    check({name, ":bit_errors"}, 32'(bad_bits), 32'd0);
    check({name, ":eop_pulses"}, 32'(eop_n), 32'(exp_eop));
    check({name, ":rx_error_pulses"}, 32'(err_n), 32'(exp_err));
    check({name, ":receiving_seen"}, 32'(rcv_seen), 32'd1);
    check({name, ":receiving_end"}, 32'(receiving), 32'd0);
    check({name, ":receiving_timing"}, 32'(bad_rcv), 32'd0);
    check({name, ":exclusive"}, 32'(excl_n), 32'd0);
    // J edge -> 2 sync clocks -> resync -> CPB/2 to sample -> 1 register
    if (exp_eop) check({name, ":eop_latency"}, 32'(eop_cyc - j_cyc), 32'(3 + CPB / 2));
  endtask

  // ---------------------------------------------------------------------------
  // Table of packet vectors
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] payload;
    logic [5:0]  nbits;
    logic        stuff;
    logic        drift;
    logic [2:0]  n_se0;
    logic [5:0]  exp_strobes;
    logic        exp_eop;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 6;
  vec_t  tbl      [NVEC];
  string tbl_name [NVEC];

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    tbl[0] = '{32'h0000_00A5, 6'd8,  1'b1, 1'b0, 3'd2, 6'd16, 1'b1, 1'b0};
    tbl[1] = '{32'h0000_00FF, 6'd8,  1'b1, 1'b0, 3'd2, 6'd16, 1'b1, 1'b0};
    tbl[2] = '{32'h0000_0000, 6'd8,  1'b1, 1'b0, 3'd2, 6'd16, 1'b1, 1'b0};
    // No stuffing: SYNC's final 1 plus 5 payload 1s delivered, then error
    tbl[3] = '{32'h0000_00FF, 6'd8,  1'b0, 1'b0, 3'd2, 6'd13, 1'b0, 1'b1};
    tbl[4] = '{32'h5A3C_F00F, 6'd32, 1'b1, 1'b1, 3'd2, 6'd40, 1'b1, 1'b0};
    tbl[5] = '{32'hFFFF_FFFF, 6'd24, 1'b1, 1'b1, 3'd2, 6'd32, 1'b1, 1'b0};
    tbl_name[0] = "byte_a5";
    tbl_name[1] = "ones_stuffed";
    tbl_name[2] = "zeros";
    tbl_name[3] = "stuff_error";
    tbl_name[4] = "drift_40bits";
    tbl_name[5] = "drift_ones";

    rst     = 1'b1;
    d_plus  = 1'b1;
    d_minus = 1'b0;
    drift   = 1'b0;
    bit_idx = 0;
    lvl     = 1'b1;
    j_cyc   = 0;
    clear_mon();

    // Reset held while the lines toggle
    repeat (20) begin
      @(negedge clk);
      d_plus  = 1'($urandom_range(0, 1));
      d_minus = 1'($urandom_range(0, 1));
    end
    #1;
    check("reset:outputs", 32'({d_orig, shift_enable, receiving, eop, rx_error}), 32'b10000);

    // Release into a J idle line: nothing may happen
    @(negedge clk);
    d_plus  = 1'b1;
    d_minus = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    repeat (50) @(negedge clk);
    check("idle:strobes", 32'(rx_q.size()), 32'd0);
    check("idle:receiving", 32'(rcv_seen), 32'd0);
    check("idle:pulses", 32'(eop_n + err_n), 32'd0);

    // Table-driven packets
    for (int i = 0; i < NVEC; i++) begin
      load_sync();
      for (int b = 0; b < int'(tbl[i].nbits); b++) tx_bits.push_back(tbl[i].payload[b]);
      run_packet(tbl_name[i], tbl[i].stuff, tbl[i].drift, int'(tbl[i].n_se0),
                 int'(tbl[i].exp_strobes), tbl[i].exp_eop, tbl[i].exp_err);
    end

    // Three SE0 bit times mid-packet is malformed; a fourth SE0 then J ends
    // error recovery.
    load_sync();
    tx_bits.push_back(1'b1); tx_bits.push_back(1'b0);
    tx_bits.push_back(1'b1); tx_bits.push_back(1'b1);
    run_packet("se0_x3", 1'b1, 1'b0, 4, 12, 1'b0, 1'b1);

    // Reset in the middle of a byte
    clear_mon();
    drift   = 1'b0;
    bit_idx = 0;
    lvl     = 1'b1;
    load_sync();
    for (int b = 0; b < 8; b++) tx_bits.push_back(b == 0 || b == 2 || b == 5 || b == 7);
    emit_line(1'b1, 1'b0, 12);
    send_stream(1'b1, 11);
    d_plus  = 1'b0;
    d_minus = 1'b1;
    #23;
    check("rst_mid:receiving_before", 32'(receiving), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid:outputs", 32'({d_orig, shift_enable, receiving, eop, rx_error}), 32'b10000);
    d_plus  = 1'b1;
    d_minus = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    load_sync();
    for (int b = 0; b < 8; b++) tx_bits.push_back(b == 0 || b == 2 || b == 5 || b == 7);
    run_packet("after_rst", 1'b1, 1'b0, 2, 16, 1'b1, 1'b0);

    // Randomised packets, biased toward 1s to exercise stuffing
    for (int k = 0; k < 12; k++) begin
      int  nb;
      bit  dr;
      nb = int'($urandom_range(1, 24));
      dr = 1'($urandom_range(0, 1));
      load_sync();
      for (int b = 0; b < nb; b++) tx_bits.push_back($urandom_range(0, 3) != 0);
      run_packet($sformatf("rand%0d", k), 1'b1, dr, 2, 8 + nb, 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
